bram_sdp_byte_write_pipe: RTL and testbench

Simple dual-port block RAM with per-column write enables, a parametrised read pipeline, a selectable same-address collision policy and an optional post-reset clear engine. It stores weights and activations behind the accelerator's datapath. It targets block-RAM inference, but it adds defined read timing (valid strobe), deterministic initial contents and defined read/write collision behaviour.

---
 rtl/bram_sdp_byte_write_pipe.sv | 184 ++++++++++++++++++
 tb/tb_bram_sdp_byte_write_pipe.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_byte_write_pipe.sv
// Simple dual-port block RAM with per-column write strobes, a valid-tagged
// read pipeline, selectable same-address collision policy and a post-reset
// clear engine that zeroes every word.
module bram_sdp_byte_write_pipe #(
    parameter int unsigned NUMBER_OF_COLUMNS = 8,
    parameter int unsigned COLUMN_WIDTH      = 16,
    parameter int unsigned DEPTH             = 128,
    parameter int unsigned READ_LATENCY      = 2,
    parameter int unsigned COLLISION_MODE    = 0,
    parameter int unsigned CLEAR_ON_RESET    = 1,
    localparam int unsigned ADDR_WIDTH       = $clog2(DEPTH),
    localparam int unsigned DATA_WIDTH       = NUMBER_OF_COLUMNS * COLUMN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [NUMBER_OF_COLUMNS-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]        addra,
    input  logic [DATA_WIDTH-1:0]        dina,
    input  logic                         enb,
    input  logic [ADDR_WIDTH-1:0]        addrb,
    output logic [DATA_WIDTH-1:0]        doutb,
    output logic                         doutb_valid,
    output logic                         init_busy
);

    localparam int unsigned NC = NUMBER_OF_COLUMNS;
    localparam int unsigned CW = COLUMN_WIDTH;
    localparam int unsigned RL = READ_LATENCY;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e                  RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_WIDTH-1:0]   LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    busy_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [RL-1:0]           stg_vld_q;
    logic [DATA_WIDTH-1:0]   stg_data_q [RL];
    logic [RL-1:0]           stg_in_vld_c;
    logic [DATA_WIDTH-1:0]   stg_in_data_c [RL];
    logic [DATA_WIDTH-1:0]   doutb_q;
    logic                    doutb_valid_q;

    logic                    clearing_c;
    logic                    user_wr_c;
    logic                    rd_acc_c;
    logic                    wr_in_range_c;
    logic                    rd_in_range_c;
    logic                    wr_en_c;
    logic [ADDR_WIDTH-1:0]   wr_addr_c;
    logic [DATA_WIDTH-1:0]   wr_data_c;
    logic [NC-1:0]           wr_strb_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;

    // Request qualification: ports only act in READY and outside reset
    assign wr_in_range_c = 32'(addra) < DEPTH;
    assign rd_in_range_c = 32'(addrb) < DEPTH;
    assign clearing_c    = rst_n && (state_q == ST_CLEAR);
    assign user_wr_c     = rst_n && (state_q == ST_READY) && ena && wr_in_range_c;
    assign rd_acc_c      = rst_n && (state_q == ST_READY) && enb;

    // FSM state register and clear counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            busy_q    <= (RST_STATE == ST_CLEAR);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= (state_d == ST_CLEAR);
        end
    end

    // FSM next state: walk every address once, then open the ports
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LAST_ADDR) begin
                state_d   = ST_READY;
                clr_cnt_d = '0;
            end
        end
    end

    // Single write port shared by the clear engine and port A
    always_comb begin
        wr_en_c   = 1'b0;
        wr_addr_c = addra;
        wr_data_c = dina;
        wr_strb_c = wea;
        if (clearing_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = clr_cnt_q;
            wr_data_c = '0;
            wr_strb_c = '1;
        end else if (user_wr_c) begin
            wr_en_c   = 1'b1;
        end
    end

    // Memory array with column write strobes; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned c = 0; c < NC; c++) begin
                if (wr_strb_c[c]) begin
                    mem_q[wr_addr_c][c*CW +: CW] <= wr_data_c[c*CW +: CW];
                end
            end
        end
    end

    // Read word: pre-write contents, optionally bypassing strobed columns
    always_comb begin
        rd_word_c = '0;
        if (rd_in_range_c) begin
            rd_word_c = mem_q[addrb];
        end
        if ((COLLISION_MODE == 1) && user_wr_c && (addra == addrb)) begin
            for (int unsigned c = 0; c < NC; c++) begin
                if (wea[c]) begin
                    rd_word_c[c*CW +: CW] = dina[c*CW +: CW];
                end
            end
        end
    end

    // Stage inputs: stage 0 takes the RAM read, later stages shift
    always_comb begin
        stg_in_vld_c = '0;
        for (int unsigned i = 0; i < RL; i++) begin
            stg_in_data_c[i] = '0;
        end
        stg_in_vld_c[0]  = rd_acc_c;
        stg_in_data_c[0] = rd_word_c;
        for (int unsigned i = 1; i < RL; i++) begin
            stg_in_vld_c[i]  = stg_vld_q[i-1];
            stg_in_data_c[i] = stg_data_q[i-1];
        end
    end

    // Free-running read pipeline; reset drops in-flight tokens
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_vld_q <= '0;
            for (int unsigned i = 0; i < RL; i++) begin
                stg_data_q[i] <= '0;
            end
        end else begin
            stg_vld_q <= stg_in_vld_c;
            for (int unsigned i = 0; i < RL; i++) begin
                stg_data_q[i] <= stg_in_data_c[i];
            end
        end
    end

    // Output register: loads only when a valid token leaves the pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            doutb_q       <= '0;
            doutb_valid_q <= 1'b0;
        end else begin
            doutb_valid_q <= stg_vld_q[RL-1];
            if (stg_vld_q[RL-1]) begin
                doutb_q <= stg_data_q[RL-1];
            end
        end
    end

    assign doutb       = doutb_q;
    assign doutb_valid = doutb_valid_q;
    assign init_busy   = busy_q;

endmodule

// File: tb/tb_bram_sdp_byte_write_pipe.sv
// Scoreboard bench: three DUTs (latency 1/2/3, mixed collision modes) share
// one stimulus stream; expected words are queued per DUT at issue time.
module tb_bram_sdp_byte_write_pipe;

    localparam int unsigned NC    = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned DW    = NC * CW;
    localparam int unsigned DEPTH = 100;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LAT  [3] = '{1, 2, 3};
    localparam int unsigned MODE [3] = '{0, 1, 1};

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          enb;
    logic [NC-1:0] wea;
    logic [AW-1:0] addra;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dina;
    logic [DW-1:0] doutb [3];
    logic          doutb_valid [3];
    logic          init_busy [3];

    int unsigned   cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] model [DEPTH];
    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rep(input logic [CW-1:0] v);
        return {NC{v}};
    endfunction

    function automatic int qsize(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int idx);
        case (idx)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push_exp(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        exp_t e_m;

        bram_sdp_byte_write_pipe #(
            .NUMBER_OF_COLUMNS (NC),
            .COLUMN_WIDTH      (CW),
            .DEPTH             (DEPTH),
            .READ_LATENCY      (LAT[g]),
            .COLLISION_MODE    (MODE[g]),
            .CLEAR_ON_RESET    (1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ena         (ena),
            .wea         (wea),
            .addra       (addra),
            .dina        (dina),
            .enb         (enb),
            .addrb       (addrb),
            .doutb       (doutb[g]),
            .doutb_valid (doutb_valid[g]),
            .init_busy   (init_busy[g])
        );

        // Compare each output strobe against the oldest queued expectation
        always @(negedge clk) begin
            if (doutb_valid[g] === 1'b1) begin
                if (qsize(g) == 0) begin
                    check_eq($sformatf("unexpected_valid%0d", g), DW'(doutb_valid[g]), '0);
                end else begin
                    e_m = pop_exp(g);
                    check_eq($sformatf("rd_data%0d", g), doutb[g], e_m.data);
                    check_eq($sformatf("rd_latency%0d", g), DW'(cyc), DW'(e_m.due));
                end
            end
        end
    end

    // One cycle of stimulus; tracked requests update model and scoreboard
    task automatic drive(input bit wen, input logic [NC-1:0] strb, input int unsigned wa,
                         input logic [DW-1:0] wd, input bit ren, input int unsigned ra,
                         input bit track);
        logic [DW-1:0] old_w;
        logic [DW-1:0] fwd_w;
        exp_t          e;
        ena   = wen;
        wea   = strb;
        addra = AW'(wa);
        dina  = wd;
        enb   = ren;
        addrb = AW'(ra);
        if (track && ren) begin
            old_w = (ra < DEPTH) ? model[ra] : '0;
            fwd_w = old_w;
            if (wen && (wa == ra) && (wa < DEPTH)) begin
                for (int c = 0; c < NC; c++) begin
                    if (strb[c]) fwd_w[c*CW +: CW] = wd[c*CW +: CW];
                end
            end
            for (int g = 0; g < 3; g++) begin
                e.data = (MODE[g] == 1) ? fwd_w : old_w;
                e.due  = cyc + 1 + LAT[g];
                push_exp(g, e);
            end
        end
        if (track && wen && (wa < DEPTH)) begin
            for (int c = 0; c < NC; c++) begin
                if (strb[c]) model[wa][c*CW +: CW] = wd[c*CW +: CW];
            end
        end
        @(negedge clk);
        ena = 1'b0;
        enb = 1'b0;
    endtask

    task automatic idle(input int n);
        ena = 1'b0;
        enb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Release reset and time the clear; optionally poke both ports mid-clear
    task automatic release_and_clear(input bit poke);
        int n;
        n = 0;
        rst_n = 1'b1;
        while ((init_busy[0] === 1'b1) && (n < 300)) begin
            if (poke && (n == 50)) begin
                ena = 1'b1; wea = '1; addra = AW'(3); dina = '1;
                enb = 1'b1; addrb = AW'(3);
            end else begin
                ena = 1'b0; enb = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        ena = 1'b0;
        enb = 1'b0;
        check_eq("clear_cycles", DW'(n), DW'(DEPTH));
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("busy_after_clear%0d", g), DW'(init_busy[g]), '0);
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("%s_doutb%0d", tag, g), doutb[g], '0);
            check_eq($sformatf("%s_valid%0d", tag, g), DW'(doutb_valid[g]), '0);
            check_eq($sformatf("%s_busy%0d", tag, g), DW'(init_busy[g]), DW'(1));
        end
    endtask

    initial begin
        int unsigned wa;
        int unsigned ra;
        rst_n = 1'b0;
        ena   = 1'b0;
        enb   = 1'b0;
        wea   = '0;
        addra = '0;
        addrb = '0;
        dina  = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (3) @(negedge clk);
        check_reset_state("reset");

        release_and_clear(1'b1);

        // Every word reads back zero after the clear, including the poked one
        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, 0, '0, 1'b1, a, 1'b1);

        // Out-of-range read and dropped out-of-range write
        drive(1'b0, '0, 0, '0, 1'b1, 100, 1'b1);
        drive(1'b1, '1, 100, rep(16'hDEAD), 1'b0, 0, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 100, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 99, 1'b1);

        // Column-masked write, read on the following edge
        drive(1'b1, '1, 5, rep(16'hFFFF), 1'b0, 0, 1'b1);
        drive(1'b1, 8'h01, 5, rep(16'h1234), 1'b0, 0, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 5, 1'b1);

        // Back-to-back reads of three distinct words
        drive(1'b1, '1, 3, rep(16'h0303), 1'b0, 0, 1'b1);
        drive(1'b1, '1, 4, rep(16'h0404), 1'b0, 0, 1'b1);
        idle(4);
        drive(1'b0, '0, 0, '0, 1'b1, 3, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 4, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 5, 1'b1);
        idle(5);

        // Same-edge collision on address 7
        drive(1'b1, '1, 7, rep(16'hAAAA), 1'b0, 0, 1'b1);
        drive(1'b1, 8'h0F, 7, rep(16'h5555), 1'b1, 7, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 7, 1'b1);

        // Random mixed traffic with frequent collisions and some out-of-range
        for (int k = 0; k < 120; k++) begin
            wa = $urandom_range(104);
            ra = ((k % 3) == 0) ? wa : $urandom_range(104);
            drive(1'($urandom_range(1)), NC'($urandom), wa,
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(1)), ra, 1'b1);
        end
        idle(6);

        // Reset lands one edge after an accepted read: no strobe for it
        drive(1'b0, '0, 0, '0, 1'b1, 9, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("midread");

        release_and_clear(1'b0);
        drive(1'b0, '0, 0, '0, 1'b1, 0, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 9, 1'b1);
        drive(1'b0, '0, 0, '0, 1'b1, 99, 1'b1);
        idle(6);

        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("drained%0d", g), DW'(qsize(g)), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
